// File: rtl/change_payout_pkg.sv
// Shared types and constants for the change payout hopper controller.
package change_payout_pkg;

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE, FAULT} state_t;
    typedef enum logic [1:0] {NICKEL, DIME, QUARTER} coin_t;

    localparam logic [3:0] NICKEL_VAL  = 4'd1;
    localparam logic [3:0] DIME_VAL    = 4'd2;
    localparam logic [3:0] QUARTER_VAL = 4'd5;

    function automatic logic [3:0] coin_value(input coin_t c);
        case (c)
            QUARTER: return QUARTER_VAL;
            DIME:    return DIME_VAL;
            default: return NICKEL_VAL;
        endcase
    endfunction

    // Inventory add that clamps at the 6-bit maximum instead of wrapping.
    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [3:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {3'b000, b};
        return s[6] ? 6'd63 : s[5:0];
    endfunction

endpackage

// File: rtl/change_payout_timer.sv
// Shared cycle counter for the eject timeout and the inter-coin gap.
module payout_timer #(
    parameter int unsigned TIMEOUT_CYC = 200,
    parameter int unsigned GAP_CYC     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout_tc,
    output logic gap_tc
);

    localparam int unsigned MAX_CYC = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int unsigned W       = $clog2(MAX_CYC + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !(&cnt)) begin
            cnt <= cnt + W'(1);
        end
    end

    // Terminal counts flag the last cycle of the window, so the state leaves on that edge.
    assign timeout_tc = (cnt == W'(TIMEOUT_CYC - 1));
    assign gap_tc     = (cnt == W'(GAP_CYC - 1));

endmodule

// File: rtl/change_payout.sv
// Greedy coin payout controller: picks coins, drives hopper solenoids, tracks inventory.
module change_payout
    import change_payout_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 200,
    parameter int unsigned GAP_CYC     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [3:0] req_amt,
    output logic       req_ready,
    input  logic       refill_valid,
    input  logic [1:0] refill_type,
    input  logic [3:0] refill_cnt,
    input  logic       coin_sensed,
    output logic       eject_nickel,
    output logic       eject_dime,
    output logic       eject_quarter,
    output logic       done,
    output logic       short,
    output logic [3:0] remain,
    output logic       fault,
    input  logic       fault_clr,
    output logic [5:0] inv_n,
    output logic [5:0] inv_d,
    output logic [5:0] inv_q
);

    state_t state;
    coin_t  coin;
    logic   tmr_clr;
    logic   tmr_en;
    logic   timeout_tc;
    logic   gap_tc;

    assign req_ready = (state == IDLE);
    assign tmr_en    = (state == EJECT) || (state == GAP);
    assign tmr_clr   = !tmr_en || ((state == EJECT) && coin_sensed);

    payout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .GAP_CYC    (GAP_CYC)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (tmr_clr),
        .en        (tmr_en),
        .timeout_tc(timeout_tc),
        .gap_tc    (gap_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            coin          <= NICKEL;
            eject_nickel  <= 1'b0;
            eject_dime    <= 1'b0;
            eject_quarter <= 1'b0;
            done          <= 1'b0;
            short         <= 1'b0;
            fault         <= 1'b0;
            remain        <= '0;
            inv_n         <= '0;
            inv_d         <= '0;
            inv_q         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        remain <= req_amt;
                        state  <= SELECT;
                    end else if (refill_valid) begin
                        case (refill_type)
                            2'd0:    inv_n <= sat_add(inv_n, refill_cnt);
                            2'd1:    inv_d <= sat_add(inv_d, refill_cnt);
                            2'd2:    inv_q <= sat_add(inv_q, refill_cnt);
                            default: ;
                        endcase
                    end
                end
                SELECT: begin
                    if (remain == '0) begin
                        done  <= 1'b1;
                        short <= 1'b0;
                        state <= DONE;
                    end else if (remain >= QUARTER_VAL && inv_q != '0) begin
                        coin          <= QUARTER;
                        eject_quarter <= 1'b1;
                        state         <= EJECT;
                    end else if (remain >= DIME_VAL && inv_d != '0) begin
                        coin       <= DIME;
                        eject_dime <= 1'b1;
                        state      <= EJECT;
                    end else if (inv_n != '0) begin
                        coin         <= NICKEL;
                        eject_nickel <= 1'b1;
                        state        <= EJECT;
                    end else begin
                        done  <= 1'b1;
                        short <= 1'b1;
                        state <= DONE;
                    end
                end
                EJECT: begin
                    // A confirmed coin wins over a timeout landing on the same cycle.
                    if (coin_sensed) begin
                        remain <= remain - coin_value(coin);
                        case (coin)
                            NICKEL:  inv_n <= inv_n - 6'd1;
                            DIME:    inv_d <= inv_d - 6'd1;
                            QUARTER: inv_q <= inv_q - 6'd1;
                            default: ;
                        endcase
                        eject_nickel  <= 1'b0;
                        eject_dime    <= 1'b0;
                        eject_quarter <= 1'b0;
                        state         <= GAP;
                    end else if (timeout_tc) begin
                        eject_nickel  <= 1'b0;
                        eject_dime    <= 1'b0;
                        eject_quarter <= 1'b0;
                        fault         <= 1'b1;
                        state         <= FAULT;
                    end
                end
                GAP: begin
                    if (gap_tc) state <= SELECT;
                end
                DONE: begin
                    short <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    if (fault_clr) begin
                        fault <= 1'b0;
                        done  <= 1'b1;
                        short <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/change_payout.md
CHANGE_PAYOUT -- requirements
Module: change_payout

Interface
REQ-001 The block SHALL use a single clock domain with synchronous, active-low reset.
REQ-002 Parameter TIMEOUT_CYC SHALL default to 200: the maximum number of EJECT cycles allowed without coin_sensed.
REQ-003 Parameter GAP_CYC SHALL default to 4: the number of idle cycles between successive ejects.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  change request
- req_amt  in  4  change owed, in nickel units (0..15, i.e. 0..75c)
- req_ready  out  1  high in IDLE only
- refill_valid  in  1  inventory load
- refill_type  in  2  0 nickel, 1 dime, 2 quarter, 3 ignored
- refill_cnt  in  4  coins added
- coin_sensed  in  1  one-cycle pulse from hopper sensor confirming a coin dropped
- eject_nickel, eject_dime, eject_quarter  out  1 each  hopper solenoid drive, at most one high
- done  out  1  one-cycle pulse at end of request
- short  out  1  valid with done; owed amount not fully paid
- remain  out  4  unpaid nickel units, valid with done
- fault  out  1  sticky hopper timeout
- fault_clr  in  1  clears fault
- inv_n, inv_d, inv_q  out  6 each  coin inventory counts

Function
REQ-005 The FSM SHALL have the states IDLE, SELECT, EJECT, GAP, DONE and FAULT.
REQ-006 In IDLE, req_valid=1 SHALL latch req_amt into remain and move to SELECT on the next cycle.
REQ-007 When both requests are present in IDLE, req_valid SHALL take priority over refill_valid; the refill is dropped.
REQ-008 Refill SHALL be honoured only in IDLE: inv_x += refill_cnt, saturating at 63; refill_type=3 SHALL be a no-op.
REQ-009 SELECT SHALL last one cycle and choose the first match in greedy order:
- remain=0 -> DONE
- remain>=5 and inv_q>0 -> quarter
- remain>=2 and inv_d>0 -> dime
- remain>=1 and inv_n>0 -> nickel
- otherwise -> DONE with short=1
REQ-010 When a coin is chosen, the next state SHALL be EJECT, with the matching eject_x held high for the whole of EJECT and the timer cleared.
REQ-011 In EJECT, coin_sensed SHALL decrement remain by 5, 2 or 1, decrement the matching inv_x by 1, drop eject_x on the following cycle and go to GAP.
REQ-012 GAP SHALL last exactly GAP_CYC cycles with all eject outputs low, then return to SELECT.
REQ-013 coin_sensed outside EJECT SHALL be ignored, with no change to inventory or remain.
REQ-014 If the timer reaches TIMEOUT_CYC in EJECT without coin_sensed, the block SHALL drop eject_x and go to FAULT.
REQ-015 FAULT SHALL assert fault, keep req_ready low and hold until fault_clr=1; it SHALL then go to DONE with short=1 and remain set to the unpaid amount.
REQ-016 DONE SHALL last one cycle: done=1, with short and remain valid, then IDLE.
REQ-017 A req_amt=0 request SHALL reach DONE with short=0, remain=0 and no eject.
REQ-018 remain and inv_x SHALL never underflow; decrements SHALL occur only on confirmed coins.

Reset
REQ-019 rst_n=0 SHALL force the following on the next clk edge, and SHALL abort any eject in progress:
- state IDLE
- all eject outputs 0
- done=0, short=0, fault=0
- remain=0, timer=0
- inv_n=inv_d=inv_q=0

Structure
REQ-020 A shared package SHALL hold the state enum, the coin-type enum (NICKEL, DIME, QUARTER) and the coin values 1, 2, 5.
REQ-021 The timeout/gap counter SHALL be one sub-module, payout_timer, with clear, enable and terminal-count outputs.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Refill 3 quarters, 3 dimes, 3 nickels; req_amt=8; coin_sensed 3 cycles into each EJECT -> quarter, dime, nickel ejects; done, short=0; inv = 2/2/2.
- inv_q=0, inv_d=0, inv_n=2; req_amt=3 -> two nickel ejects; done, short=1, remain=1.
- req_amt=5, never assert coin_sensed -> eject_quarter drops after 200 cycles; fault=1; after fault_clr, done with short=1, remain=5.
- req_amt=0 -> done 2 cycles after acceptance; no eject.
- coin_sensed pulsed in IDLE and GAP -> inventory and remain unchanged.
- rst_n low during EJECT -> eject outputs 0 and state IDLE next cycle; refill_valid and req_valid together in IDLE -> request taken, inventory unchanged.
